// File: rtl/hdpldadapt_cmn_occ_burst_ctrl.sv
// rtl/hdpldadapt_cmn_occ_burst_ctrl.sv - multi-channel OCC capture burst controller
// Counts a settling delay after the synchronised scan_enable fall, then gates per-channel pulse bursts.
module hdpldadapt_cmn_occ_burst_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    user_clk,
  input  logic                    rst_n,
  input  logic                    scan_enable,
  input  logic                    occ_enable,
  input  logic                    atpg_mode,
  input  logic [NUM_CH*CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0]        burst_dly,
  output logic [NUM_CH-1:0]       occ_user_clken,
  output logic                    occ_busy,
  output logic                    occ_done,
  output logic                    occ_abort
);

  typedef enum logic [2:0] {IDLE, ARM, DELAY, BURST, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  se_sync;
  logic                    se_s;
  logic                    bypass;
  logic [NUM_CH*CNT_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0]        dly_q, dly_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_CH-1:0]       clken_q, clken_nxt;
  logic                    busy_q, done_q, abort_q, abort_nxt;

  assign bypass = !(atpg_mode && occ_enable);
  assign se_s   = se_sync[SYNC_STAGES-1];

  function automatic logic [CNT_W-1:0] max_len(input logic [NUM_CH*CNT_W-1:0] v);
    logic [CNT_W-1:0] m;
    m = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (v[c*CNT_W +: CNT_W] > m) m = v[c*CNT_W +: CNT_W];
    end
    return m;
  endfunction

  // Channel c is enabled on burst cycle idx while idx is below its pulse count.
  function automatic logic [NUM_CH-1:0] clken_for(input logic [NUM_CH*CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] idx);
    logic [NUM_CH-1:0] e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) e[c] = (idx < v[c*CNT_W +: CNT_W]);
    return e;
  endfunction

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    dly_nxt   = dly_q;
    cnt_nxt   = cnt;
    clken_nxt = '0;
    abort_nxt = 1'b0;
    if (bypass) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (se_s) state_nxt = ARM;
        ARM: begin
          if (!se_s) begin
            len_nxt = burst_len;
            dly_nxt = burst_dly;
            cnt_nxt = '0;
            if (burst_dly != '0) begin
              state_nxt = DELAY;
            end else if (max_len(burst_len) == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = BURST;
              clken_nxt = clken_for(burst_len, '0);
            end
          end
        end
        DELAY: begin
          if (se_s) begin
            state_nxt = ARM;
            abort_nxt = 1'b1;
            cnt_nxt   = '0;
          end else if (cnt == dly_q - CNT_W'(1)) begin
            cnt_nxt = '0;
            if (max_len(len_q) == '0) begin
              state_nxt = DONE;
            end else begin
              state_nxt = BURST;
              clken_nxt = clken_for(len_q, '0);
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        BURST: begin
          if (se_s) begin
            state_nxt = ARM;
            abort_nxt = 1'b1;
            cnt_nxt   = '0;
          end else if (cnt == max_len(len_q) - CNT_W'(1)) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            clken_nxt = clken_for(len_q, cnt + CNT_W'(1));
          end
        end
        DONE: if (se_s) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      se_sync <= '1;
      state   <= IDLE;
      len_q   <= '0;
      dly_q   <= '0;
      cnt     <= '0;
      clken_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      se_sync <= {se_sync[SYNC_STAGES-2:0], scan_enable};
      state   <= state_nxt;
      len_q   <= len_nxt;
      dly_q   <= dly_nxt;
      cnt     <= cnt_nxt;
      clken_q <= clken_nxt;
      busy_q  <= (state_nxt == DELAY) || (state_nxt == BURST);
      done_q  <= (state_nxt == DONE);
      abort_q <= abort_nxt;
    end
  end

  // Bypass overrides the registered enables combinationally, even while held in reset.
  assign occ_user_clken = bypass ? '1 : clken_q;
  assign occ_busy       = busy_q  && !bypass;
  assign occ_done       = done_q  && !bypass;
  assign occ_abort      = abort_q && !bypass;

endmodule

// File: tb/tb_hdpldadapt_cmn_occ_burst_ctrl.sv
// tb/tb_hdpldadapt_cmn_occ_burst_ctrl.sv - self-checking bench for the OCC burst controller
module tb_hdpldadapt_cmn_occ_burst_ctrl;

  logic       user_clk = 1'b0;
  logic       rst_n, scan_enable, occ_enable, atpg_mode;
  logic [5:0] burst_len;
  logic [2:0] burst_dly;
  logic [1:0] occ_user_clken;
  logic       occ_busy, occ_done, occ_abort;
  int         checks = 0;
  int         errors = 0;

  hdpldadapt_cmn_occ_burst_ctrl #(.NUM_CH(2), .CNT_W(3), .SYNC_STAGES(2)) dut (
    .user_clk(user_clk), .rst_n(rst_n), .scan_enable(scan_enable),
    .occ_enable(occ_enable), .atpg_mode(atpg_mode), .burst_len(burst_len),
    .burst_dly(burst_dly), .occ_user_clken(occ_user_clken), .occ_busy(occ_busy),
    .occ_done(occ_done), .occ_abort(occ_abort)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    int l0, l1, dly, k;
    int first, done_e, c0, c1, ab;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [4:0] obs();
    return {occ_user_clken, occ_busy, occ_done, occ_abort};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual={clken,busy,done,abort}=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // Edge j counts from the first edge sampling scan_enable=0; k is the edge sampling its re-rise (0 = none).
  function automatic logic [4:0] model(input int l0, input int l1, input int dly, input int k, input int j);
    int m, s;
    logic [1:0] ck;
    logic b, d, a;
    m = (l0 > l1) ? l0 : l1;
    s = 3 + dly;
    if (k != 0 && j >= k + 2) begin
      ck = 2'b00; b = 1'b0; d = 1'b0;
      a = (j == k + 2) && (k + 1 >= 3) && (k + 1 <= s + m - 1);
    end else begin
      ck[0] = (j >= s) && (j < s + l0);
      ck[1] = (j >= s) && (j < s + l1);
      b = (j >= 3) && (j <= s + m - 1);
      d = (j >= s + m);
      a = 1'b0;
    end
    return {ck, b, d, a};
  endfunction

  task automatic run_burst(input int l0, input int l1, input int dly, input int k,
                           output int first, output int done_e, output int c0,
                           output int c1, output int ab);
    scan_enable = 1'b1;
    repeat (4) tick();
    burst_len   = {3'(l1), 3'(l0)};
    burst_dly   = 3'(dly);
    scan_enable = 1'b0;
    first = 0; done_e = 0; c0 = 0; c1 = 0; ab = 0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      check($sformatf("burst l=%0d/%0d d=%0d k=%0d e%0d", l1, l0, dly, k, j), obs(),
            model(l0, l1, dly, k, j));
      if (occ_user_clken != 2'b00 && first == 0) first = j;
      if (occ_done && done_e == 0) done_e = j;
      c0 += int'(occ_user_clken[0]);
      c1 += int'(occ_user_clken[1]);
      ab += int'(occ_abort);
      if (j >= 3) begin
        burst_len = 6'($urandom);
        burst_dly = 3'($urandom);
      end
      if (k != 0 && j == k - 1) scan_enable = 1'b1;
    end
  endtask

  initial begin
    int first, done_e, c0, c1, ab, l0, l1, dly, k, m;
    tbl[0] = '{l0:1, l1:3, dly:0, k:0, first:3, done_e:6,  c0:1, c1:3, ab:0};
    tbl[1] = '{l0:0, l1:7, dly:5, k:0, first:8, done_e:15, c0:0, c1:7, ab:0};
    tbl[2] = '{l0:0, l1:0, dly:2, k:0, first:0, done_e:5,  c0:0, c1:0, ab:0};
    tbl[3] = '{l0:6, l1:6, dly:0, k:5, first:3, done_e:0,  c0:4, c1:4, ab:1};
    tbl[4] = '{l0:6, l1:6, dly:0, k:0, first:3, done_e:9,  c0:6, c1:6, ab:0};
    tbl[5] = '{l0:0, l1:0, dly:0, k:0, first:0, done_e:3,  c0:0, c1:0, ab:0};

    rst_n = 1'b0; atpg_mode = 1'b1; occ_enable = 1'b1; scan_enable = 1'b1;
    burst_len = '0; burst_dly = '0;
    #12;
    check("reset occ mode", obs(), 5'b00000);
    atpg_mode = 1'b0;
    #1;
    check("reset bypass", obs(), 5'b11000);
    @(negedge user_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      scan_enable = 1'($urandom);
      tick();
      check($sformatf("bypass %0d", i), obs(), 5'b11000);
    end
    atpg_mode = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_burst(tbl[i].l0, tbl[i].l1, tbl[i].dly, tbl[i].k, first, done_e, c0, c1, ab);
      check_i($sformatf("vec%0d first", i), first, tbl[i].first);
      check_i($sformatf("vec%0d done", i), done_e, tbl[i].done_e);
      check_i($sformatf("vec%0d ch0 pulses", i), c0, tbl[i].c0);
      check_i($sformatf("vec%0d ch1 pulses", i), c1, tbl[i].c1);
      check_i($sformatf("vec%0d aborts", i), ab, tbl[i].ab);
    end

    // Asynchronous reset in the middle of a burst.
    scan_enable = 1'b1;
    repeat (4) tick();
    burst_len = 6'o77; burst_dly = 3'd0; scan_enable = 1'b0;
    repeat (4) tick();
    check("pre-reset burst", obs(), 5'b11100);
    #2 rst_n = 1'b0;
    #1 check("async reset clears", obs(), 5'b00000);
    atpg_mode = 1'b0;
    #1 check("bypass in reset", obs(), 5'b11000);
    atpg_mode = 1'b1;
    #3 rst_n = 1'b1;
    tick();
    check("after reset", obs(), 5'b00000);

    for (int i = 0; i < 30; i++) begin
      l0 = $urandom_range(7, 0);
      l1 = $urandom_range(7, 0);
      dly = $urandom_range(7, 0);
      m = (l0 > l1) ? l0 : l1;
      k = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(3 + dly + m + 1, 2);
      run_burst(l0, l1, dly, k, first, done_e, c0, c1, ab);
    end

    // Mode exit mid-burst, then the FSM must idle without re-arming.
    scan_enable = 1'b1;
    repeat (4) tick();
    burst_len = 6'o77; burst_dly = 3'd0; scan_enable = 1'b0;
    repeat (5) tick();
    check("mid burst", obs(), 5'b11100);
    burst_len = 6'o11;
    tick();
    check("reconfig ignored", obs(), 5'b11100);
    occ_enable = 1'b0;
    #1 check("mode exit immediate", obs(), 5'b11000);
    tick();
    check("mode exit edge", obs(), 5'b11000);
    occ_enable = 1'b1;
    #1 check("re-enter idle", obs(), 5'b00000);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle hold %0d", i), obs(), 5'b00000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdpldadapt_cmn_occ_burst_ctrl.md
# hdpldadapt_cmn_occ_burst_ctrl

Parametrised on-chip-clock (OCC) burst controller for the adapter's DFT clocking. It replaces the fixed two-pulse enable logic with a multi-channel engine. NUM_CH user-clock gates each receive a programmable capture burst of 0..2^CNT_W-1 pulses, and the burst start is preceded by a programmable settling delay. The block runs entirely in the user_clk domain and drives the clock-enable inputs of the per-channel OCC clock gates that feed the user/test clock muxes.

## Interface
- NUM_CH, 2, number of independently gated user-clock channels (>=1)
- CNT_W, 3, width of burst length and delay fields; maximum burst is 2^CNT_W-1 pulses
- SYNC_STAGES, 2, synchroniser depth for scan_enable (>=2)
- user_clk  in  1  functional user clock; the only clock of the block
- rst_n  in  1  asynchronous active-low reset
- scan_enable  in  1  tester scan enable, active high, asynchronous to user_clk
- occ_enable  in  1  OCC enable, active high, quasi-static
- atpg_mode  in  1  test mode, active high, quasi-static
- burst_len  in  NUM_CH*CNT_W  per-channel pulse count; channel c is bits [c*CNT_W +: CNT_W]; 0 means no pulses
- burst_dly  in  CNT_W  user_clk cycles to wait after the scan_enable fall before the first pulse
- occ_user_clken  out  NUM_CH  per-channel clock-gate enable
- occ_busy  out  1  high in DELAY or BURST
- occ_done  out  1  high in DONE (the burst completed)
- occ_abort  out  1  one-cycle pulse when a burst is aborted

## Operation
- Bypass:
  - Active when atpg_mode=0 or occ_enable=0.
  - occ_user_clken is all ones, combinationally from the mode pins and independent of rst_n.
  - The FSM is held in IDLE synchronously.
  - occ_busy, occ_done and occ_abort are 0.
- OCC mode (atpg_mode=1 and occ_enable=1):
  - occ_user_clken is the registered enable vector clken_q.
  - scan_enable passes through SYNC_STAGES flops, which reset to 1; the synchroniser output is se_s.
- FSM states: IDLE, ARM, DELAY, BURST, DONE.
  - IDLE: clken_q=0. If se_s=1, go to ARM.
  - ARM (shift in progress): clken_q=0. If se_s=0:
    - Capture burst_len into len_q and burst_dly into dly_q. Later changes to either input are ignored until the next ARM.
    - If dly_q!=0, go to DELAY with cnt=0.
    - Otherwise go to BURST.
  - DELAY: cnt increments each cycle. When cnt==dly_q-1, go to BURST.
  - BURST: cnt runs 0..M-1, where M = max over c of len_q[c].
    - clken_q[c] is high for the cycles with cnt < len_q[c].
    - The edge that enters BURST loads clken_q[c] = (len_q[c]!=0).
    - Each channel's pulses are consecutive and all channels start on the same cycle.
    - When the last pulse cycle ends, clken_q=0 and the FSM goes to DONE.
    - If M=0, the FSM goes from ARM or DELAY directly to DONE and no enable is asserted.
  - DONE: clken_q=0, occ_done=1. If se_s=1, go to ARM (next shift/capture cycle).
- Abort: se_s=1 while in DELAY or BURST:
  - The FSM goes to ARM and clken_q=0 on that edge.
  - occ_abort pulses for one cycle.
  - occ_done is not asserted.
- Mode exit mid-burst (atpg_mode or occ_enable falls): the FSM goes to IDLE on the next edge and occ_user_clken is all ones immediately (bypass).
- cnt is CNT_W bits wide and never wraps, because M and dly_q are at most 2^CNT_W-1.

## Timing
- Reset values:
  - FSM in IDLE, synchroniser flops 1, clken_q 0, cnt 0.
  - occ_busy, occ_done and occ_abort are 0.
  - occ_user_clken is all ones in bypass and 0 in OCC mode.
- All outputs except the bypass path are registered on the user_clk rising edge. This makes them glitch-free for the downstream latch-based clock gates.
- Burst start latency: count the user_clk edge that first samples scan_enable=0 as edge 1. clken_q rises after edge SYNC_STAGES+burst_dly+1.
- Pulse width: occ_user_clken[c] is high for exactly len_q[c] consecutive cycles, i.e. len_q[c] gated clock pulses.
- occ_done rises one edge after the last enable cycle, or at the DELAY/ARM exit when M=0.
- Abort response: clken_q falls at the edge after se_s=1, which is SYNC_STAGES+1 edges after the scan_enable rise.
- When se_s=1 and the DELAY end or last BURST cycle occur on the same edge, abort wins: the FSM goes to ARM with no occ_done.
- Asserting rst_n mid-burst asynchronously clears clken_q and the state within the reset propagation time.

## Test plan
- Bypass: atpg_mode=0 with arbitrary scan_enable.
  - Required: occ_user_clken=all ones, also during rst_n=0; busy, done and abort stay 0.
- Basic burst: NUM_CH=2, CNT_W=3, SYNC_STAGES=2, burst_len={3,1}, burst_dly=0; scan_enable 1 then 0.
  - ch1 enable is high for 3 cycles starting after edge 3.
  - ch0 enable is high for 1 cycle on the first of those cycles.
  - occ_done rises on the following edge.
- Delay and max length: burst_dly=5, burst_len={7,0}.
  - First enable appears after edge 8.
  - ch1 enable is high for 7 cycles; ch0 stays 0 throughout.
- Zero burst: burst_len all 0, burst_dly=2.
  - No enable pulses.
  - occ_busy high for 2 cycles, then occ_done=1.
- Abort: raise scan_enable during BURST cycle 2 of a 6-pulse burst.
  - Enables drop 3 edges after the rise.
  - occ_abort pulses once, occ_done stays 0.
  - The next scan_enable fall produces a full 6-pulse burst.
- Reconfiguration and mode exit: change burst_len during BURST and check the running burst is unchanged. Then drop occ_enable mid-burst.
  - Required: occ_user_clken goes to all ones immediately and the FSM is in IDLE on the next edge.
